// File: rtl/bram_pkg.sv
// Shared constants for the BRAM request controller: response FIFO depth and a byte-lane merge helper.
// Purely declarative; no latency or backpressure of its own.
package bram_pkg;

    localparam int RESP_FIFO_DEPTH = 2;
    localparam int RESP_CNT_W      = $clog2(RESP_FIFO_DEPTH + 1);

    // One byte lane of a byte-enabled write: enabled lanes take new data, others keep old.
    function automatic logic [7:0] merge_byte(input logic [7:0] old_byte,
                                              input logic [7:0] new_byte,
                                              input logic       en);
        return en ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/bram_req_ctrl_if.sv
// Request/response and RAM-port bundle for bram_req_ctrl; slave = controller view, master = requester/RAM view.
// Wiring only; latency and backpressure are defined by the controller.
interface bram_req_ctrl_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [BE_WIDTH-1:0]   wr_be;

    logic                  rd_valid;
    logic                  rd_ready;
    logic [ADDR_WIDTH-1:0] rd_addr;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_data;

    logic                  ram_we;
    logic [BE_WIDTH-1:0]   ram_be;
    logic [ADDR_WIDTH-1:0] ram_wr_addr;
    logic [DATA_WIDTH-1:0] ram_di;
    logic [ADDR_WIDTH-1:0] ram_rd_addr;
    logic [DATA_WIDTH-1:0] ram_do;

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_be, rd_valid, rd_addr, resp_ready, ram_do,
        output wr_ready, rd_ready, resp_valid, resp_data,
               ram_we, ram_be, ram_wr_addr, ram_di, ram_rd_addr
    );

    modport master (
        output wr_valid, wr_addr, wr_data, wr_be, rd_valid, rd_addr, resp_ready, ram_do,
        input  wr_ready, rd_ready, resp_valid, resp_data,
               ram_we, ram_be, ram_wr_addr, ram_di, ram_rd_addr
    );

endinterface

// File: rtl/bram_resp_fifo.sv
// bram_resp_fifo: in-order read-response buffer, push becomes visible on the next cycle.
// No internal backpressure: the caller's credit check keeps pushes within depth; head data is registered and stable.
module bram_resp_fifo
    import bram_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_dat_i,
    input  logic                  pop_i,
    output logic [RESP_CNT_W-1:0] count_o,
    output logic                  vld_o,
    output logic [DATA_WIDTH-1:0] dat_o
);
    localparam int PTR_W = (RESP_FIFO_DEPTH > 1) ? $clog2(RESP_FIFO_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [RESP_FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [RESP_CNT_W-1:0] cnt_q, cnt_d;
    logic                  do_push, do_pop;

    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && ((cnt_q != RESP_CNT_W'(RESP_FIFO_DEPTH)) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + RESP_CNT_W'(1);
            2'b01:   cnt_d = cnt_q - RESP_CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RESP_FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign vld_o   = (cnt_q != '0);
    assign dat_o   = mem_q[rd_ptr_q];

endmodule

// File: rtl/bram_req_ctrl.sv
// bram_req_ctrl: valid/ready front end for a 1-cycle BRAM; writes pass through combinationally, reads return in 2 cycles.
// Reads are credit-limited to the 2-entry response FIFO and stall on same-address write collisions (BRAM_REQ_CTRL_FWD_EN forwards full-word ones).
module bram_req_ctrl
    import bram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input logic            clk,
    input logic            rst_n,
    bram_req_ctrl_if.slave bus
);
    localparam int OCC_W = RESP_CNT_W + 1;

    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [BE_WIDTH-1:0]   wr_be;

    logic                  wr_fire, rd_fire, rd_ready, rd_stall, collision;
    logic                  resp_vld, resp_pop, credit_ok;
    logic [DATA_WIDTH-1:0] resp_dat, push_dat;
    logic [RESP_CNT_W-1:0] fifo_count;
    logic [OCC_W-1:0]      occupied;
    logic                  inflight_q, inflight_d;

    assign wr_addr = bus.wr_addr;
    assign wr_data = bus.wr_data;
    assign wr_be   = bus.wr_be;
    assign rd_addr = bus.rd_addr;

    // Writes are never backpressured while out of reset.
    assign bus.wr_ready    = rst_n;
    assign wr_fire         = bus.wr_valid && rst_n;
    assign bus.ram_we      = wr_fire;
    assign bus.ram_wr_addr = wr_fire ? wr_addr : '0;
    assign bus.ram_di      = wr_fire ? wr_data : '0;
    assign bus.ram_be      = wr_fire ? wr_be   : '0;
    assign bus.ram_rd_addr = rst_n   ? rd_addr : '0;

    assign collision = bus.rd_valid && bus.wr_valid && (rd_addr == wr_addr);
`ifdef BRAM_REQ_CTRL_FWD_EN
    assign rd_stall  = collision && !(&wr_be);
`else
    assign rd_stall  = collision;
`endif

    // Slots already spoken for: buffered + one read in the RAM pipe, minus the one leaving now.
    assign resp_pop  = resp_vld && bus.resp_ready;
    assign occupied  = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(resp_pop);
    assign credit_ok = occupied < OCC_W'(RESP_FIFO_DEPTH);
    assign rd_ready  = rst_n && credit_ok && !rd_stall;
    assign rd_fire   = bus.rd_valid && rd_ready;
    assign inflight_d = rd_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inflight_q <= 1'b0;
        else        inflight_q <= inflight_d;
    end

`ifdef BRAM_REQ_CTRL_FWD_EN
    // RAM_DO is undefined on a collision, so the accepted read takes the write word instead.
    logic                  fwd_vld_q, fwd_vld_d;
    logic [DATA_WIDTH-1:0] fwd_dat_q, fwd_dat_d;

    assign fwd_vld_d = rd_fire && collision;
    assign fwd_dat_d = fwd_vld_d ? wr_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_vld_q <= 1'b0;
            fwd_dat_q <= '0;
        end else begin
            fwd_vld_q <= fwd_vld_d;
            fwd_dat_q <= fwd_dat_d;
        end
    end

    assign push_dat = fwd_vld_q ? fwd_dat_q : bus.ram_do;
`else
    assign push_dat = bus.ram_do;
`endif

    bram_resp_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_resp_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (inflight_q),
        .push_dat_i (push_dat),
        .pop_i      (resp_pop),
        .count_o    (fifo_count),
        .vld_o      (resp_vld),
        .dat_o      (resp_dat)
    );

    assign bus.rd_ready   = rd_ready;
    assign bus.resp_valid = resp_vld;
    assign bus.resp_data  = resp_dat;

endmodule

// File: tb/tb_bram_req_ctrl.sv
// Bench for bram_req_ctrl: behavioural RAM, queue-based reference model, vector table and directed corner sequences.
// Build with BRAM_REQ_CTRL_FWD_EN defined to exercise the forwarding variant.
module tb_bram_req_ctrl;
    import bram_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = 4;
`ifdef BRAM_REQ_CTRL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bram_req_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) bus ();

    bram_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural BRAM: one-cycle read, read-before-write, garbage on same-address collision.
    logic [DW-1:0] ram_mem [1 << AW];
    always @(posedge clk) begin
        logic [DW-1:0] w;
        if (bus.ram_we && bus.ram_rd_addr == bus.ram_wr_addr) bus.ram_do <= DW'($urandom);
        else                                                 bus.ram_do <= ram_mem[bus.ram_rd_addr];
        if (bus.ram_we) begin
            w = ram_mem[bus.ram_wr_addr];
            for (int b = 0; b < BW; b++)
                w[b*8 +: 8] = merge_byte(w[b*8 +: 8], bus.ram_di[b*8 +: 8], bus.ram_be[b]);
            ram_mem[bus.ram_wr_addr] = w;
        end
    end

    // Reference model: outstanding responses tagged with their accept cycle.
    typedef struct { logic [DW-1:0] dat; int cyc; } exp_t;
    exp_t          q[$];
    logic [DW-1:0] ref_mem [1 << AW];
    int            cyc = 0;
    int            errors = 0;
    int            checks = 0;
    logic          m_pop, m_rfire;
    logic [DW-1:0] m_rdat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [BW-1:0] wb, input logic rv, input logic [AW-1:0] ra,
                         input logic rr);
        bus.wr_valid   = wv;
        bus.wr_addr    = wa;
        bus.wr_data    = wd;
        bus.wr_be      = wb;
        bus.rd_valid   = rv;
        bus.rd_addr    = ra;
        bus.resp_ready = rr;
    endtask

    task automatic model_check();
        logic exp_vld, col, stall, exp_rdy;
        int   occ;
        exp_vld = (q.size() > 0) && (cyc - q[0].cyc >= 2);
        m_pop   = exp_vld && bus.resp_ready;
        col     = bus.rd_valid && bus.wr_valid && (bus.rd_addr == bus.wr_addr);
        stall   = col && (!FWD || bus.wr_be != '1);
        occ     = q.size() - (m_pop ? 1 : 0);
        exp_rdy = (occ < 2) && !stall;
        m_rfire = bus.rd_valid && exp_rdy;
        m_rdat  = col ? bus.wr_data : ref_mem[bus.rd_addr];
        chk("m_wr_ready", bus.wr_ready, 1);
        chk("m_rd_ready", bus.rd_ready, exp_rdy);
        chk("m_resp_valid", bus.resp_valid, exp_vld);
        if (exp_vld) chk("m_resp_data", bus.resp_data, q[0].dat);
        chk("m_ram_we", bus.ram_we, bus.wr_valid);
        if (bus.wr_valid) begin
            chk("m_ram_wr_addr", bus.ram_wr_addr, bus.wr_addr);
            chk("m_ram_di", bus.ram_di, bus.wr_data);
            chk("m_ram_be", bus.ram_be, bus.wr_be);
        end
        chk("m_ram_rd_addr", bus.ram_rd_addr, bus.rd_addr);
    endtask

    task automatic model_update();
        logic [DW-1:0] w;
        if (m_pop) void'(q.pop_front());
        if (m_rfire) q.push_back('{m_rdat, cyc});
        if (bus.wr_valid) begin
            w = ref_mem[bus.wr_addr];
            for (int b = 0; b < BW; b++)
                if (bus.wr_be[b]) w[b*8 +: 8] = bus.wr_data[b*8 +: 8];
            ref_mem[bus.wr_addr] = w;
        end
        cyc++;
    endtask

    // Inputs are set at the falling edge; check, then advance one clock.
    task automatic tick();
        #1;
        model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    typedef struct {
        logic wv; logic [AW-1:0] wa; logic [DW-1:0] wd; logic [BW-1:0] wb;
        logic rv; logic [AW-1:0] ra;
        logic e_rdy; logic e_vld; logic [DW-1:0] e_dat;
    } vec_t;
    localparam int NV = 15;
    vec_t tbl [NV];

    task automatic set_vec(input int i, input logic wv, input logic [AW-1:0] wa,
                           input logic [DW-1:0] wd, input logic [BW-1:0] wb,
                           input logic rv, input logic [AW-1:0] ra,
                           input logic e_rdy, input logic e_vld, input logic [DW-1:0] e_dat);
        tbl[i] = '{wv, wa, wd, wb, rv, ra, e_rdy, e_vld, e_dat};
    endtask

    initial begin
        logic [DW-1:0] v;
        for (int i = 0; i < (1 << AW); i++) begin
            v = DW'($urandom);
            ram_mem[i] = v;
            ref_mem[i] = v;
        end

        // Reset state, with a write request pending to show the RAM port stays quiet.
        drive(1'b1, 10'd1, 32'h5555_AAAA, 4'hF, 1'b1, 10'd2, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rd_ready", bus.rd_ready, 0);
        chk("rst_wr_ready", bus.wr_ready, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_ram_we", bus.ram_we, 0);
        chk("rst_resp_data", bus.resp_data, 0);
        chk("rst_ram_wr_addr", bus.ram_wr_addr, 0);
        @(negedge clk);
        drive(1'b0, 10'd0, 32'h0, 4'h0, 1'b0, 10'd0, 1'b1);
        rst_n = 1'b1;

        // Vector table: write-then-read latency, byte merge, collision handling.
        set_vec(0,  1, 10'd5, 32'hDEADBEEF, 4'hF, 0, 10'd0, 1, 0, 32'h0);
        set_vec(1,  0, 10'd0, 32'h0,        4'h0, 1, 10'd5, 1, 0, 32'h0);
        set_vec(2,  0, 10'd0, 32'h0,        4'h0, 0, 10'd0, 1, 0, 32'h0);
        set_vec(3,  0, 10'd0, 32'h0,        4'h0, 0, 10'd0, 1, 1, 32'hDEADBEEF);
        set_vec(4,  1, 10'd7, 32'h11223344, 4'hF, 0, 10'd0, 1, 0, 32'h0);
        set_vec(5,  1, 10'd7, 32'hAABBCCDD, 4'h5, 0, 10'd0, 1, 0, 32'h0);
        set_vec(6,  0, 10'd0, 32'h0,        4'h0, 1, 10'd7, 1, 0, 32'h0);
        set_vec(7,  0, 10'd0, 32'h0,        4'h0, 0, 10'd0, 1, 0, 32'h0);
        set_vec(8,  0, 10'd0, 32'h0,        4'h0, 0, 10'd0, 1, 1, 32'h11BB33DD);
        set_vec(9,  1, 10'd3, 32'hCAFEF00D, 4'hF, 1, 10'd3, FWD, 0, 32'h0);
        set_vec(10, 0, 10'd0, 32'h0,        4'h0, !FWD, 10'd3, 1, 0, 32'h0);
        set_vec(11, 0, 10'd0, 32'h0,        4'h0, 0, 10'd0, 1, FWD, 32'hCAFEF00D);
        set_vec(12, 0, 10'd0, 32'h0,        4'h0, 0, 10'd0, 1, !FWD, 32'hCAFEF00D);
        set_vec(13, 1, 10'd3, 32'h12345678, 4'h3, 1, 10'd3, 0, 0, 32'h0);
        set_vec(14, 0, 10'd0, 32'h0,        4'h0, 0, 10'd0, 1, 0, 32'h0);
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].wb, tbl[i].rv, tbl[i].ra, 1'b1);
            #1;
            chk($sformatf("vec%0d_rd_ready", i), bus.rd_ready, tbl[i].e_rdy);
            chk($sformatf("vec%0d_resp_valid", i), bus.resp_valid, tbl[i].e_vld);
            if (tbl[i].e_vld) chk($sformatf("vec%0d_resp_data", i), bus.resp_data, tbl[i].e_dat);
            tick();
        end

        // Back-to-back reads with RESP_READY high: one per cycle, in order, consecutive responses.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, AW'(32 + i), 32'hA500_0000 + DW'(i), 4'hF, 1'b0, 10'd0, 1'b1);
            tick();
        end
        for (int i = 0; i < 11; i++) begin
            drive(1'b0, 10'd0, 32'h0, 4'h0, i < 8, AW'(32 + i), 1'b1);
            #1;
            if (i < 8) chk($sformatf("b2b%0d_rd_ready", i), bus.rd_ready, 1);
            chk($sformatf("b2b%0d_resp_valid", i), bus.resp_valid, (i >= 2 && i < 10));
            if (i >= 2 && i < 10)
                chk($sformatf("b2b%0d_resp_data", i), bus.resp_data, 32'hA500_0000 + DW'(i - 2));
            tick();
        end

        // Four reads against a stalled consumer: two accepted, head held, then in-order drain.
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 10'd0, 32'h0, 4'h0, i < 4, AW'(32 + i), i >= 4);
            #1;
            if (i < 4) chk($sformatf("bp%0d_rd_ready", i), bus.rd_ready, i < 2);
            chk($sformatf("bp%0d_resp_valid", i), bus.resp_valid, (i >= 2 && i < 6));
            if (i >= 2 && i < 6)
                chk($sformatf("bp%0d_resp_data", i), bus.resp_data, (i == 5) ? 32'hA500_0001 : 32'hA500_0000);
            tick();
        end

        // Reset one cycle after a read fire, with another response parked in the FIFO.
        drive(1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 10'd5, 1'b0);
        tick();
        drive(1'b0, 10'd0, 32'h0, 4'h0, 1'b0, 10'd0, 1'b0);
        tick();
        tick();
        drive(1'b0, 10'd0, 32'h0, 4'h0, 1'b1, 10'd7, 1'b0);
        #1;
        chk("prerst_resp_data", bus.resp_data, 32'hDEADBEEF);
        tick();
        drive(1'b1, 10'd9, 32'h0BAD_0BAD, 4'hF, 1'b1, 10'd7, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_rd_ready", bus.rd_ready, 0);
        chk("arst_wr_ready", bus.wr_ready, 0);
        chk("arst_resp_valid", bus.resp_valid, 0);
        chk("arst_ram_we", bus.ram_we, 0);
        chk("arst_resp_data", bus.resp_data, 0);
        chk("arst_ram_di", bus.ram_di, 0);
        q.delete();
        @(negedge clk);
        drive(1'b0, 10'd0, 32'h0, 4'h0, 1'b0, 10'd0, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("postrst%0d_resp_valid", i), bus.resp_valid, 0);
            tick();
        end

        // Randomized traffic on a small address window to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            logic [BW-1:0] wb;
            wb = ($urandom_range(0, 1) == 0) ? 4'hF : BW'($urandom_range(0, 15));
            drive($urandom_range(0, 2) == 0, AW'($urandom_range(0, 7)), DW'($urandom), wb,
                  $urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
            tick();
        end
        drive(1'b0, 10'd0, 32'h0, 4'h0, 1'b0, 10'd0, 1'b1);
        repeat (6) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bram_req_ctrl.md
BRAM_REQ_CTRL -- requirements
Module: bram_req_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, word address width of the attached RAM.
REQ-002 Parameter DATA_WIDTH, default 32, data width, SHALL be a multiple of 8.
REQ-003 Parameter BE_WIDTH, default DATA_WIDTH/8, number of byte-enable bits.
REQ-004 CLK  in  1  single clock; all state on posedge CLK.
REQ-005 RST_N  in  1  reset, asynchronous, active-low.
REQ-006 WR_VALID / WR_READY  in / out  1 / 1  write request handshake.
REQ-007 WR_ADDR, WR_DATA, WR_BE  in  ADDR_WIDTH, DATA_WIDTH, BE_WIDTH  write address, data, byte enables.
REQ-008 RD_VALID / RD_READY  in / out  1 / 1  read request handshake.
REQ-009 RD_ADDR  in  ADDR_WIDTH  read address.
REQ-010 RESP_VALID / RESP_READY  out / in  1 / 1  read response handshake.
REQ-011 RESP_DATA  out  DATA_WIDTH  read response data.
REQ-012 RAM_WE, RAM_BE, RAM_WR_ADDR, RAM_DI  out  1, BE_WIDTH, ADDR_WIDTH, DATA_WIDTH  RAM write port drive.
REQ-013 RAM_RD_ADDR out ADDR_WIDTH; RAM_DO in DATA_WIDTH  RAM read port; RAM_DO valid one cycle after the address is presented; RAM_DO is undefined when read and write hit the same address in the same cycle.

Function
REQ-014 Write fire (WR_VALID && WR_READY) SHALL drive RAM_WE=1, RAM_WR_ADDR=WR_ADDR, RAM_DI=WR_DATA, RAM_BE=WR_BE combinationally in the same cycle; otherwise RAM_WE=0.
REQ-015 WR_READY SHALL be 1 whenever RST_N is high; writes always take priority.
REQ-016 RAM_RD_ADDR SHALL equal RD_ADDR combinationally; a read fire at cycle t SHALL capture RAM_DO at the end of cycle t+1 into the response FIFO.
REQ-017 Minimum read latency SHALL be 2 cycles: a read fire at cycle t gives RESP_VALID=1 at t+2 when the FIFO was empty.
REQ-018 Response FIFO depth SHALL be 2; responses SHALL be returned in request order; none dropped or duplicated.
REQ-019 Credit rule: RD_READY=1 only if fifo_count + inflight - (RESP_VALID && RESP_READY) < 2, where inflight is 1 for a read fired in the previous cycle.
REQ-020 With RESP_READY held high, RD_READY SHALL stay high, giving one read per cycle sustained.
REQ-021 Collision: when RD_VALID, WR_VALID, and RD_ADDR==WR_ADDR in the same cycle, with the forwarding feature absent, RD_READY SHALL be 0 for that cycle.
REQ-022 A read fired in the cycle after a write to the same address SHALL return the newly written bytes merged with the old bytes.
REQ-023 RESP_DATA SHALL hold stable while RESP_VALID && !RESP_READY.

Reset
REQ-024 RST_N low SHALL immediately force RESP_VALID=0, RD_READY=0, WR_READY=0, RAM_WE=0, fifo_count=0, inflight=0; all registered data outputs SHALL be 0.
REQ-025 A read in flight when reset asserts SHALL be discarded; no response SHALL appear after reset deasserts.
REQ-026 RAM contents SHALL not be touched by reset.

Configuration
REQ-027 Macro BRAM_REQ_CTRL_FWD_EN: when defined, a collision with WR_BE all-ones SHALL be accepted, and its response SHALL carry WR_DATA instead of RAM_DO.
REQ-028 With BRAM_REQ_CTRL_FWD_EN defined, a collision with a partial WR_BE SHALL stall as in REQ-021.
REQ-029 Without BRAM_REQ_CTRL_FWD_EN, every collision SHALL stall and no forwarding registers SHALL exist.

Structure
REQ-030 Shared package bram_pkg SHALL hold the response FIFO depth constant (2) and the byte-merge helper function.
REQ-031 The 2-entry response FIFO SHALL be the sub-module bram_resp_fifo, with push, pop, count, and data signals.

Verification
REQ-032 Sequence: write addr 5 = 0xDEADBEEF with BE=0xF, then read addr 5 in the next cycle. Required: RESP_DATA=0xDEADBEEF exactly 2 cycles after the read fire.
REQ-033 Sequence: write addr 7 = 0x11223344 BE=0xF, then write addr 7 = 0xAABBCCDD BE=0x5, then read addr 7. Required: RESP_DATA=0x11BB33DD.
REQ-034 Sequence: 8 back-to-back reads with RESP_READY=1. Required: RD_READY stays 1, and 8 in-order responses arrive on consecutive cycles.
REQ-035 Sequence: 4 reads with RESP_READY=0. Required: 2 reads accepted, RD_READY=0 afterwards, RESP_DATA stable; after RESP_READY rises, both responses drain in order.
REQ-036 Sequence: same-cycle write and read to addr 3 with BE=0xF. Required: read stalls 1 cycle without the macro; with BRAM_REQ_CTRL_FWD_EN, read is accepted and returns the write data.
REQ-037 Sequence: assert RST_N low one cycle after a read fire. Required: all outputs 0 immediately, and no response after release.
